// File: rtl/hilo_unit.sv
// HI/LO register pair with an iterative radix-2 multiplier/divider (WIDTH+1 cycle latency)
// and MTHI/MTLO write port; drives {HI,LO} back to the ALU.
module hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_cpu,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic               mt_en,
    input  logic               mt_sel,
    input  logic [WIDTH-1:0]   mt_data,
    output logic [2*WIDTH-1:0] hilo_q,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               isdiv_q, isdiv_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] hilo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;

    always_comb begin
        a_neg = ~op[0] & rs[WIDTH-1];
        b_neg = ~op[0] & rt[WIDTH-1];
        a_mag = a_neg ? -rs : rs;
        b_mag = b_neg ? -rt : rt;

        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; borrow in the trial keeps the old remainder.
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_q};
        div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        isdiv_d = isdiv_q;
        dbz_d   = dbz_q;
        hilo_d  = hilo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    isdiv_d = op[1];
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = '0;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        mag_d   = b_mag;
                        dbz_d   = (rt == '0);
                        state_d = (rt == '0) ? FIX : RUN;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        mag_d   = a_mag;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end else if (mt_en) begin
                    if (mt_sel) hilo_d[WIDTH-1:0]       = mt_data;
                    else        hilo_d[2*WIDTH-1:WIDTH] = mt_data;
                end
            end
            RUN: begin
                acc_d = isdiv_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dbz_q)        dz_d   = 1'b1;
                else if (isdiv_q) hilo_d = {rem_fix, quo_fix};
                else              hilo_d = prod_fix;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            isdiv_q <= 1'b0;
            dbz_q   <= 1'b0;
            hilo_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            isdiv_q <= isdiv_d;
            dbz_q   <= dbz_d;
            hilo_q  <= hilo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit: mul/div results, latency, MT writes,
// divide-by-zero, ignored requests while busy and asynchronous reset mid-op.
module tb_hilo_unit;

    logic        clk_cpu;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        mt_en, mt_sel;
    logic [31:0] mt_data;
    logic [63:0] hilo_q;
    logic        busy, done, div_by_zero;

    int compared   = 0;
    int mismatched = 0;

    hilo_unit #(.WIDTH(32)) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .mt_en      (mt_en),
        .mt_sel     (mt_sel),
        .mt_data    (mt_data),
        .hilo_q     (hilo_q),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op and follows it to done; checks latency, busy length, stability and result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_mt, input bit inject,
                          input logic [63:0] exp, input bit exp_dbz, input int exp_lat);
        logic [63:0] pre;
        int  samples, busyc;
        bit  got, stable, overlap, dz_seen;
        @(negedge clk_cpu);
        pre     = hilo_q;
        op      = o;
        rs      = a;
        rt      = b;
        start   = 1'b1;
        mt_en   = with_mt;
        mt_sel  = 1'b1;
        mt_data = 32'hDEADBEEF;
        @(posedge clk_cpu);
        #1;
        start   = 1'b0;
        mt_en   = 1'b0;
        samples = 0;
        busyc   = 0;
        got     = 1'b0;
        stable  = 1'b1;
        overlap = 1'b0;
        dz_seen = 1'b0;
        while (!got && samples < 100) begin
            @(negedge clk_cpu);
            samples++;
            if (busy) busyc++;
            if (busy && hilo_q !== pre) stable = 1'b0;
            if (done) begin
                got     = 1'b1;
                dz_seen = div_by_zero;
                overlap = busy;
            end
            if (inject && samples == 5) begin
                start   = 1'b1;
                op      = 2'd1;
                rs      = 32'h11111111;
                rt      = 32'h22222222;
                mt_en   = 1'b1;
                mt_sel  = 1'b0;
                mt_data = 32'hFFFF0000;
            end else if (inject && samples == 6) begin
                start = 1'b0;
                mt_en = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(samples - 1), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busyc), 64'(exp_lat));
        check({tag, "_busy_with_done"}, 64'(overlap), 64'd0);
        check({tag, "_dbz"}, 64'(dz_seen), 64'(exp_dbz));
        check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
        check({tag, "_hilo"}, hilo_q, exp);
        @(negedge clk_cpu);
        check({tag, "_done_one_cycle"}, {62'd0, done, div_by_zero}, 64'd0);
    endtask

    initial begin
        bit late_done;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        rs      = '0;
        rt      = '0;
        mt_en   = 1'b0;
        mt_sel  = 1'b0;
        mt_data = '0;
        repeat (2) @(negedge clk_cpu);
        check("reset_hilo", hilo_q, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        reset = 1'b1;

        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 33);
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 1'b0, 33);
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
        run_op("divu", 2'd3, 32'd7, 32'd2, 1'b0, 1'b0, 64'h00000001_00000003, 1'b0, 33);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h00000000_80000000, 1'b0, 33);

        @(negedge clk_cpu);
        mt_en   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'h12345678;
        @(posedge clk_cpu);
        #1;
        check("mthi", hilo_q, 64'h12345678_80000000);
        @(negedge clk_cpu);
        mt_sel  = 1'b1;
        mt_data = 32'h9ABCDEF0;
        @(posedge clk_cpu);
        #1;
        check("mtlo", hilo_q, 64'h12345678_9ABCDEF0);
        mt_en = 1'b0;
        @(negedge clk_cpu);
        check("mt_no_done", 64'(done), 64'd0);

        run_op("divu_zero", 2'd3, 32'd55, 32'd0, 1'b0, 1'b0, 64'h12345678_9ABCDEF0, 1'b1, 1);
        run_op("busy_ignore", 2'd0, 32'd5, 32'd7, 1'b0, 1'b1, 64'h00000000_00000023, 1'b0, 33);
        run_op("start_wins", 2'd1, 32'd3, 32'd4, 1'b1, 1'b0, 64'h00000000_0000000C, 1'b0, 33);

        @(negedge clk_cpu);
        op    = 2'd2;
        rs    = 32'd100;
        rt    = 32'd3;
        start = 1'b1;
        @(posedge clk_cpu);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk_cpu);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_hilo", hilo_q, 64'd0);
        check("async_rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clk_cpu);
        reset = 1'b1;
        late_done = 1'b0;
        repeat (40) begin
            @(negedge clk_cpu);
            if (done || busy) late_done = 1'b1;
        end
        check("no_done_after_rst", 64'(late_done), 64'd0);

        run_op("mult_after_rst", 2'd0, 32'd5, 32'd6, 1'b0, 1'b0, 64'h00000000_0000001E, 1'b0, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
Owns the architectural HI/LO register pair and is the consumer/producer at the far end of the ALU's hilo interface. It accepts MULT/MULTU/DIV/DIVU issue requests and computes them iteratively, one bit per cycle. It also accepts MTHI/MTLO writes and drives hilo_q back to the ALU for MFHI/MFLO. It provides busy/done handshakes so the pipeline stalls HI/LO consumers until a result lands.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iterative latency is WIDTH+1 cycles.

Ports:
clk_cpu  in  1  CPU clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  issue pulse for a mul/div op; sampled only in IDLE.
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
rs  in  WIDTH  multiplicand / dividend; sampled with start.
rt  in  WIDTH  multiplier / divisor; sampled with start.
mt_en  in  1  move-to-HI/LO write strobe.
mt_sel  in  1  0=write HI, 1=write LO.
mt_data  in  WIDTH  data for MTHI/MTLO.
hilo_q  out  2*WIDTH  {HI,LO}, registered.
busy  out  1  high while an op is in flight.
done  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with rt==0.

Behaviour:
- Reset (reset==0, asynchronous): hilo_q=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0. Any in-flight op is discarded with no done.
- States:
  - IDLE: waits for start or mt_en.
  - RUN: WIDTH iterations.
  - FIX: sign correction and writeback, then back to IDLE.
- IDLE with start=1 at edge k:
  - Capture magnitudes of rs/rt. Signed ops take two's-complement absolute values; unsigned ops take them raw.
  - Record result sign and op; counter=0; go to RUN; busy=1 from edge k.
- RUN, one iteration per edge:
  - Multiply: shift-add, radix-2.
  - Divide: restoring, radix-2.
  - After edge k+WIDTH (counter reaches WIDTH-1), go to FIX.
- FIX at edge k+WIDTH+1:
  - Apply signs and write HI/LO; busy=0; done=1 for exactly one cycle.
  - Total latency is 33 cycles at WIDTH=32.
- Multiply result: HI = upper WIDTH bits and LO = lower WIDTH bits of the 2*WIDTH-bit product. Signed product is negated if operand signs differ.
- Divide result:
  - LO = quotient, truncated toward zero; HI = remainder.
  - Signed: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0. No exception.
- Divide by zero (rt==0 at start, DIV or DIVU):
  - No iteration; HI/LO unchanged.
  - At edge k+1: busy returns to 0; done=1 and div_by_zero=1 for one cycle.
  - busy is high only for the cycle between edges k and k+1.
- mt_en in IDLE with start=0: the selected half of hilo_q is written with mt_data at that edge; the other half is held; no done pulse.
- Simultaneous start and mt_en in IDLE: start wins; mt_en is ignored.
- start or mt_en while busy (RUN/FIX): ignored with no effect. The decoder must stall on busy.
- hilo_q is stable throughout RUN/FIX, holding the pre-op value until the writeback edge.
- done and div_by_zero are never high simultaneously with busy, except that busy drops at the same edge done rises.
- The internal product and remainder accumulators are not observable.

Test Plan:
1. MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles hilo_q=0xFFFFFFFF_FFFFFFEB; done high exactly 1 cycle; busy high 33 cycles.
2. MULTU rs=rt=0xFFFFFFFF -> hilo_q=0xFFFFFFFE_00000001.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hilo_q=0x12345678_9ABCDEF0 immediately after each edge. Then DIVU rt=0 -> hilo_q unchanged; done=div_by_zero=1 one cycle after start; busy high 1 cycle.
5. Issue MULT, then assert start (different operands) and mt_en at cycle 5 of RUN -> both ignored; result matches the first op only. start+mt_en together in IDLE -> op runs, HI/LO not written by mt.
6. Start DIV, drive reset=0 asynchronously mid-cycle at iteration 10 -> hilo_q=0, busy=0 immediately; no done after release. A new MULT 5*6 afterwards gives LO=30, HI=0.
